// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: multi-cycle load/store controller between EXU, data memory and WBU
module lsu_mem_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] addr,
   input  logic        MemRd,
   input  logic        MemWr,
   input  logic [2:0]  MemOp,
   input  logic [31:0] wdata,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   output logic        mem_wen,
   output logic [31:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic        mem_rsp_valid,
   output logic        mem_rsp_ready,
   input  logic [31:0] mem_rdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rdata,
   output logic        err
);
   localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3;
   logic [1:0]  state;
   logic        drop, is_load, noop, bad_op, mis, fault;
   logic [2:0]  op;
   logic [1:0]  off;
   logic [3:0]  mask;
   logic [31:0] wdog, lane_data, shifted, load_val;
   assign req_ready     = state == S_IDLE && !drop;
   assign mem_req_valid = state == S_REQ;
   assign mem_rsp_ready = state == S_WAIT || drop;
   assign rsp_valid     = state == S_DONE;
   assign mem_wmask     = {4'b0, mask};
   // classify the incoming request, place store data on its lane, extract load data
   always_comb begin
      noop      = !MemRd && !MemWr;
      bad_op    = MemRd ? !(MemOp inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                        : !(MemOp inside {3'b000, 3'b001, 3'b010});
      mis       = (MemOp[1:0] == 2'b01 && addr[0]) || (MemOp[1:0] == 2'b10 && addr[1:0] != 2'b00);
      fault     = (MemRd && MemWr) || (!noop && (bad_op || mis));
      lane_data = MemOp[1:0] == 2'b00 ? {24'b0, wdata[7:0]} << {addr[1:0], 3'b000}
                : MemOp[1:0] == 2'b01 ? {16'b0, wdata[15:0]} << {addr[1:0], 3'b000} : wdata;
      shifted   = mem_rdata >> {off, 3'b000};
      load_val  = op == 3'b000 ? {{24{shifted[7]}}, shifted[7:0]}
                : op == 3'b001 ? {{16{shifted[15]}}, shifted[15:0]}
                : op == 3'b100 ? {24'b0, shifted[7:0]}
                : op == 3'b101 ? {16'b0, shifted[15:0]} : mem_rdata;
   end
   // transaction FSM with response watchdog and post-timeout drain of a late response
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         drop      <= 1'b0;
         wdog      <= '0;
         is_load   <= 1'b0;
         op        <= '0;
         off       <= '0;
         mem_addr  <= '0;
         mem_wen   <= 1'b0;
         mem_wdata <= '0;
         mask      <= '0;
         rdata     <= '0;
         err       <= 1'b0;
      end else begin
         if (drop && mem_rsp_valid && state != S_WAIT) drop <= 1'b0;
         case (state)
            S_IDLE: if (req_valid && req_ready) begin
               is_load <= MemRd;
               op      <= MemOp;
               off     <= addr[1:0];
               rdata   <= '0;
               err     <= fault;
               if (fault || noop) state <= S_DONE;
               else begin
                  state     <= S_REQ;
                  mem_addr  <= {addr[31:2], 2'b00};
                  mem_wen   <= MemWr;
                  mem_wdata <= MemWr ? lane_data : '0;
                  mask      <= MemWr ? (MemOp[1:0] == 2'b00 ? 4'b0001 : MemOp[1:0] == 2'b01 ? 4'b0011 : 4'b1111) << addr[1:0] : 4'b0000;
               end
            end
            S_REQ: if (mem_req_ready) begin
               state <= S_WAIT;
               wdog  <= '0;
            end
            S_WAIT: if (mem_rsp_valid) begin
               state <= S_DONE;
               rdata <= is_load ? load_val : '0;
            end else if (TIMEOUT_CYCLES != 0 && wdog == TIMEOUT_CYCLES - 1) begin
               state <= S_DONE;
               err   <= 1'b1;
               drop  <= 1'b1;
            end else wdog <= wdog + 32'd1;
            default: if (rsp_ready) state <= S_IDLE;
         endcase
      end
   end
endmodule
